v_timing_gen: RTL and testbench
===============================

// Module: v_timing_gen
// PURPOSE
//  Parametrised vertical timing generator. Advances the line counter on a selected edge of the
//  horizontal line_end strobe. Decodes v_sync, v_active and frame strobes. Adds line repeat (scan
//  doubling), sync polarity, a frame counter, run/stop gated at frame boundaries, and external resync.
//  Sits after the horizontal sync block; feeds the pixel/address generator.
// PARAMETERS
//  AV_Y           480  active lines
//  V_FRONT_PORCH  10   lines between active end and sync start
//  V_SYNC_PULSE   2    sync width, lines
//  V_BACK_PORCH   29   lines between sync end and frame wrap
//  Y_BITS         10   width of y; must satisfy Y_TOTAL <= 2**Y_BITS
//  LINE_REPEAT    1    line_ticks per y step (1..16); 2 = scan doubling
//  LINE_EDGE      0    0 = advance on falling edge of line_end, 1 = rising edge
//  V_SYNC_POL     0    level of v_sync while asserted (0 = active-low)
//  FRAME_BITS     8    frame counter width
// PORTS
//  clk          in   1           system clock, all logic on rising edge
//  reset        in   1           asynchronous, active-low reset
//  line_end     in   1           horizontal end-of-line level, synchronous to clk
//  run          in   1           enable; sampled at start and at frame wrap
//  resync       in   1           sync 1-cycle pulse: restart frame at line 0
//  y            out  Y_BITS      current line, 0..Y_TOTAL-1
//  v_sync       out  1           vertical sync, polarity per V_SYNC_POL
//  v_active     out  1           1 while RUN and y < AV_Y
//  frame_start  out  1           1-cycle pulse when line 0 begins
//  frame_cnt    out  FRAME_BITS  completed frames, wraps modulo 2**FRAME_BITS
// BEHAVIOUR
//  - Y_TOTAL = AV_Y+V_FRONT_PORCH+V_SYNC_PULSE+V_BACK_PORCH (default 521).
//  - Edge detect: line_end registered to prev; reset value of prev = LINE_EDGE ? 1 : 0 (no spurious tick).
//    tick = (LINE_EDGE ? line_end & ~prev : ~line_end & prev); combinational in the edge cycle.
//  - All outputs registered; y/flags update on the clk edge that ends the tick cycle (latency 1).
//  - Reset: state IDLE, y=0, rep=0, frame_cnt=0, frame_start=0, v_active=0, v_sync=~V_SYNC_POL.
//  - FSM IDLE: ticks ignored unless run=1. tick&&run -> RUN, y=0, rep=0, frame_start=1.
//  - FSM RUN, on tick: rep counts 0..LINE_REPEAT-1; at rep wrap y++.
//    At y==Y_TOTAL-1 with rep wrap: y=0 and frame_cnt++.
//    Then run=1 -> stay RUN, frame_start=1; run=0 -> IDLE (stop only at frame boundary).
//  - run deasserted mid-frame has no effect until that wrap.
//  - resync (any state) beats tick in same cycle: y=0, rep=0, frame_start=1, state=RUN if run else IDLE.
//    frame_cnt is not incremented.
//  - v_sync asserted (=V_SYNC_POL) iff RUN and AV_Y+V_FRONT_PORCH <= y < AV_Y+V_FRONT_PORCH+V_SYNC_PULSE.
//    Otherwise ~V_SYNC_POL.
//  - Flags are derived from next-state y so they are cycle-aligned with y.
//  - frame_start is high exactly one cycle, in the cycle y first reads 0.
//  - Async reset mid-frame: immediate return to reset values; first post-reset edge of line_end
//    only primes prev.
// STRUCTURE
//  - Shared package/header: Y_TOTAL derivation, state encodings IDLE/RUN, sync-window helper constants.
//  - Sub-module line_edge_pulse (params EDGE; clk, reset, in -> pulse) instantiated once.
//  - Top holds FSM, rep/y/frame counters and output decode.
// TESTING
//  1 Defaults, run=1, 521 falling edges -> y steps 0..520 then 0.
//    v_sync low exactly at y=490,491; v_active high for y<480; frame_cnt 0->1 at wrap.
//  2 LINE_REPEAT=2 -> y increments every 2nd tick; 1042 ticks per frame; frame_start once per frame.
//  3 run=0 at y=100 -> frame finishes to 520, returns to IDLE y=0.
//    Further ticks ignored; run=1 then tick -> RUN, frame_start pulse.
//  4 resync coincident with tick at y=300 -> y=0, frame_start=1, frame_cnt unchanged.
//  5 LINE_EDGE=1, V_SYNC_POL=1 -> advance on rising edges only; v_sync high at y=490,491.
//  6 Assert reset at y=250 with line_end held low -> all outputs at reset values.
//    Release; no tick until a true selected edge.

Source files
------------

// File: rtl/v_timing_gen_pkg.sv
`default_nettype none
// ============================================================================
// v_timing_gen_pkg : state encoding and frame-geometry helpers for v_timing_gen
// Revision 1.0
// ============================================================================
package v_timing_gen_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } vtg_state_e;

  localparam int unsigned c_rep_bits = 4;
  typedef logic [c_rep_bits-1:0] rep_t;

  function automatic int unsigned y_total(input int unsigned av, input int unsigned fp,
                                          input int unsigned sp, input int unsigned bp);
    return av + fp + sp + bp;
  endfunction

  function automatic int unsigned sync_lo(input int unsigned av, input int unsigned fp);
    return av + fp;
  endfunction

  function automatic int unsigned sync_hi(input int unsigned av, input int unsigned fp,
                                          input int unsigned sp);
    return av + fp + sp;
  endfunction

  function automatic logic in_window(input int unsigned y, input int unsigned lo,
                                     input int unsigned hi);
    return (y >= lo) && (y < hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/v_timing_gen_line_edge_pulse.sv
`default_nettype none
// ============================================================================
// v_timing_gen_line_edge_pulse : single-cycle strobe on the selected edge of in_i
// Revision 1.0
// ============================================================================
module v_timing_gen_line_edge_pulse #(
  parameter bit EDGE = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in_i,
  output logic pulse_o
);

  logic prev_q;

  // Reset to the post-edge level so a static input never produces a tick.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= EDGE;
    end else begin
      prev_q <= in_i;
    end
  end

  assign pulse_o = EDGE ? (in_i & ~prev_q) : (~in_i & prev_q);

endmodule
`default_nettype wire

// File: rtl/v_timing_gen.sv
`default_nettype none
// ============================================================================
// v_timing_gen : vertical timing generator (line counter, v_sync/v_active, frames)
// Revision 1.0
// ============================================================================
module v_timing_gen
  import v_timing_gen_pkg::*;
#(
  parameter int unsigned AV_Y          = 480,
  parameter int unsigned V_FRONT_PORCH = 10,
  parameter int unsigned V_SYNC_PULSE  = 2,
  parameter int unsigned V_BACK_PORCH  = 29,
  parameter int unsigned Y_BITS        = 10,
  parameter int unsigned LINE_REPEAT   = 1,
  parameter bit          LINE_EDGE     = 1'b0,
  parameter bit          V_SYNC_POL    = 1'b0,
  parameter int unsigned FRAME_BITS    = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  line_end_i,
  input  logic                  run_i,
  input  logic                  resync_i,
  output logic [Y_BITS-1:0]     y_o,
  output logic                  v_sync_o,
  output logic                  v_active_o,
  output logic                  frame_start_o,
  output logic [FRAME_BITS-1:0] frame_cnt_o
);

  localparam int unsigned       c_total    = y_total(AV_Y, V_FRONT_PORCH, V_SYNC_PULSE, V_BACK_PORCH);
  localparam int unsigned       c_sync_lo  = sync_lo(AV_Y, V_FRONT_PORCH);
  localparam int unsigned       c_sync_hi  = sync_hi(AV_Y, V_FRONT_PORCH, V_SYNC_PULSE);
  localparam logic [Y_BITS-1:0] c_y_last   = Y_BITS'(c_total - 1);
  localparam rep_t              c_rep_last = rep_t'(LINE_REPEAT - 1);

  logic line_tick;

  v_timing_gen_line_edge_pulse #(
    .EDGE (LINE_EDGE)
  ) u_line_edge (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .in_i    (line_end_i),
    .pulse_o (line_tick)
  );

  vtg_state_e            state_q, state_d;
  logic [Y_BITS-1:0]     y_q, y_d;
  rep_t                  rep_q, rep_d;
  logic [FRAME_BITS-1:0] frame_cnt_q, frame_cnt_d;
  logic                  frame_start_q, frame_start_d;
  logic                  v_active_q, v_active_d;
  logic                  v_sync_q, v_sync_d;

  always_comb begin
    state_d       = state_q;
    y_d           = y_q;
    rep_d         = rep_q;
    frame_cnt_d   = frame_cnt_q;
    frame_start_d = 1'b0;

    if (resync_i) begin
      y_d           = '0;
      rep_d         = '0;
      frame_start_d = 1'b1;
      state_d       = run_i ? ST_RUN : ST_IDLE;
    end else if (line_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (run_i) begin
            state_d       = ST_RUN;
            y_d           = '0;
            rep_d         = '0;
            frame_start_d = 1'b1;
          end
        end
        ST_RUN: begin
          if (rep_q == c_rep_last) begin
            rep_d = '0;
            if (y_q == c_y_last) begin
              // Frame boundary: the only point where run_i may stop the generator.
              y_d         = '0;
              frame_cnt_d = frame_cnt_q + 1'b1;
              if (run_i) begin
                frame_start_d = 1'b1;
              end else begin
                state_d = ST_IDLE;
              end
            end else begin
              y_d = y_q + 1'b1;
            end
          end else begin
            rep_d = rep_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    v_active_d = (state_d == ST_RUN) && (32'(y_d) < AV_Y);
    v_sync_d   = ((state_d == ST_RUN) && in_window(32'(y_d), c_sync_lo, c_sync_hi))
                 ? V_SYNC_POL : ~V_SYNC_POL;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      y_q           <= '0;
      rep_q         <= '0;
      frame_cnt_q   <= '0;
      frame_start_q <= 1'b0;
      v_active_q    <= 1'b0;
      v_sync_q      <= ~V_SYNC_POL;
    end else begin
      state_q       <= state_d;
      y_q           <= y_d;
      rep_q         <= rep_d;
      frame_cnt_q   <= frame_cnt_d;
      frame_start_q <= frame_start_d;
      v_active_q    <= v_active_d;
      v_sync_q      <= v_sync_d;
    end
  end

  assign y_o           = y_q;
  assign v_sync_o      = v_sync_q;
  assign v_active_o    = v_active_q;
  assign frame_start_o = frame_start_q;
  assign frame_cnt_o   = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_v_timing_gen.sv
`default_nettype none
// ============================================================================
// tb_v_timing_gen : scoreboard bench for v_timing_gen (three parameterisations)
// Revision 1.0
// ============================================================================
module tb_v_timing_gen;

  typedef struct packed {
    logic [9:0] y;
    logic       vs;
    logic       va;
    logic       fs;
    logic [7:0] fc;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       le    [3];
  logic       run_s [3];
  logic       rs_s  [3];
  logic [9:0] y_s   [3];
  logic       vs_s  [3];
  logic       va_s  [3];
  logic       fs_s  [3];
  logic [7:0] fc_s  [3];

  // d=0: defaults, d=1: scan doubling, d=2: rising edge with active-high sync
  v_timing_gen u_a (
    .clk_i(clk), .rst_ni(rst_n), .line_end_i(le[0]), .run_i(run_s[0]), .resync_i(rs_s[0]),
    .y_o(y_s[0]), .v_sync_o(vs_s[0]), .v_active_o(va_s[0]), .frame_start_o(fs_s[0]),
    .frame_cnt_o(fc_s[0]));

  v_timing_gen #(.LINE_REPEAT(2)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .line_end_i(le[1]), .run_i(run_s[1]), .resync_i(rs_s[1]),
    .y_o(y_s[1]), .v_sync_o(vs_s[1]), .v_active_o(va_s[1]), .frame_start_o(fs_s[1]),
    .frame_cnt_o(fc_s[1]));

  v_timing_gen #(.LINE_EDGE(1'b1), .V_SYNC_POL(1'b1)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .line_end_i(le[2]), .run_i(run_s[2]), .resync_i(rs_s[2]),
    .y_o(y_s[2]), .v_sync_o(vs_s[2]), .v_active_o(va_s[2]), .frame_start_o(fs_s[2]),
    .frame_cnt_o(fc_s[2]));

  int   m_y   [3];
  int   m_rep [3];
  int   m_fc  [3];
  bit   m_on  [3];
  int   rep_n [3] = '{1, 2, 1};
  bit   pol   [3] = '{1'b0, 1'b0, 1'b1};
  obs_t q_exp [$];
  obs_t exp_o, act_o;
  int   n_err = 0;
  int   n_chk = 0;

  function automatic obs_t mk(input bit on, input int yy, input int fc, input bit fs, input bit p);
    obs_t o;
    o.y  = yy[9:0];
    o.vs = (on && (yy == 490 || yy == 491)) ? p : ~p;
    o.va = on && (yy < 480);
    o.fs = fs;
    o.fc = fc[7:0];
    return o;
  endfunction

  function automatic obs_t got(input int d);
    return {y_s[d], vs_s[d], va_s[d], fs_s[d], fc_s[d]};
  endfunction

  // Level for phase 0 (no selected edge) and phase 1 (selected edge) of a line.
  function automatic logic lvl(input int d, input int ph);
    return (d == 2) ? (ph == 1) : (ph == 0);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_y[d] = 0; m_rep[d] = 0; m_fc[d] = 0; m_on[d] = 1'b0;
    end
  endtask

  // Drive one clock of stimulus, push the expected post-edge outputs, advance.
  task automatic cyc(input int d, input logic l, input logic r, input logic s, input bit tk);
    bit fs;
    fs = 1'b0;
    le[d] = l; run_s[d] = r; rs_s[d] = s;
    if (s) begin
      m_y[d] = 0; m_rep[d] = 0; fs = 1'b1; m_on[d] = r;
    end else if (tk) begin
      if (!m_on[d]) begin
        if (r) begin
          m_on[d] = 1'b1; m_y[d] = 0; m_rep[d] = 0; fs = 1'b1;
        end
      end else begin
        m_rep[d]++;
        if (m_rep[d] == rep_n[d]) begin
          m_rep[d] = 0;
          m_y[d]++;
          if (m_y[d] == 521) begin
            m_y[d]  = 0;
            m_fc[d] = (m_fc[d] + 1) % 256;
            if (r) fs = 1'b1;
            else   m_on[d] = 1'b0;
          end
        end
      end
    end
    q_exp.push_back(mk(m_on[d], m_y[d], m_fc[d], fs, pol[d]));
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      le[d] = 1'b0; run_s[d] = 1'b0; rs_s[d] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    for (int d = 0; d < 3; d++) begin
      q_exp.push_back(mk(1'b0, 0, 0, 1'b0, pol[d]));
      exp_o = q_exp.pop_front(); act_o = got(d); n_chk++;
      if (act_o !== exp_o) begin
        n_err++; $display("FAIL reset d=%0d: got %h expected %h", d, act_o, exp_o);
      end
    end
    rst_n = 1'b1;
    for (int d = 0; d < 3; d++) begin
      cyc(d, 1'b0, 1'b0, 1'b0, 1'b0);
      exp_o = q_exp.pop_front(); act_o = got(d); n_chk++;
      if (act_o !== exp_o) begin
        n_err++; $display("FAIL post_reset d=%0d: got %h expected %h", d, act_o, exp_o);
      end
    end
  endtask

  task automatic test_frame();
    int vs_lo;
    vs_lo = 0;
    for (int i = 0; i < 522; i++) begin
      for (int ph = 0; ph < 2; ph++) begin
        cyc(0, lvl(0, ph), 1'b1, 1'b0, ph == 1);
        exp_o = q_exp.pop_front(); act_o = got(0); n_chk++;
        if (act_o !== exp_o) begin
          n_err++; $display("FAIL frame i=%0d ph=%0d: got %h expected %h", i, ph, act_o, exp_o);
        end
        if (ph == 1 && vs_s[0] === 1'b0) vs_lo++;
      end
    end
    n_chk++;
    if (vs_lo != 2) begin
      n_err++; $display("FAIL frame_vsync_lines: got %0d expected 2", vs_lo);
    end
    n_chk++;
    if (y_s[0] !== 10'd0 || fc_s[0] !== 8'd1 || fs_s[0] !== 1'b1) begin
      n_err++; $display("FAIL frame_wrap: got y=%0d fc=%0d fs=%b expected y=0 fc=1 fs=1",
                        y_s[0], fc_s[0], fs_s[0]);
    end
  endtask

  task automatic test_stop();
    for (int i = 0; i < 525; i++) begin
      for (int ph = 0; ph < 2; ph++) begin
        cyc(0, lvl(0, ph), (i >= 524) || (i < 100), 1'b0, ph == 1);
        exp_o = q_exp.pop_front(); act_o = got(0); n_chk++;
        if (act_o !== exp_o) begin
          n_err++; $display("FAIL stop i=%0d ph=%0d: got %h expected %h", i, ph, act_o, exp_o);
        end
      end
      if (i == 520) begin
        n_chk++;
        if (y_s[0] !== 10'd0 || va_s[0] !== 1'b0 || fc_s[0] !== 8'd2 || fs_s[0] !== 1'b0) begin
          n_err++; $display("FAIL stop_idle: got y=%0d va=%b fc=%0d fs=%b expected y=0 va=0 fc=2 fs=0",
                            y_s[0], va_s[0], fc_s[0], fs_s[0]);
        end
      end
    end
    n_chk++;
    if (fs_s[0] !== 1'b1 || va_s[0] !== 1'b1) begin
      n_err++; $display("FAIL restart: got fs=%b va=%b expected fs=1 va=1", fs_s[0], va_s[0]);
    end
  endtask

  task automatic test_resync();
    for (int i = 0; i < 300; i++) begin
      for (int ph = 0; ph < 2; ph++) begin
        cyc(0, lvl(0, ph), 1'b1, 1'b0, ph == 1);
        exp_o = q_exp.pop_front(); act_o = got(0); n_chk++;
        if (act_o !== exp_o) begin
          n_err++; $display("FAIL resync_run i=%0d: got %h expected %h", i, act_o, exp_o);
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      cyc(0, (k != 1), 1'b1, (k == 1), (k == 1));
      exp_o = q_exp.pop_front(); act_o = got(0); n_chk++;
      if (act_o !== exp_o) begin
        n_err++; $display("FAIL resync k=%0d: got %h expected %h", k, act_o, exp_o);
      end
      if (k == 1) begin
        n_chk++;
        if (y_s[0] !== 10'd0 || fs_s[0] !== 1'b1 || fc_s[0] !== 8'd2) begin
          n_err++; $display("FAIL resync_frame: got y=%0d fs=%b fc=%0d expected y=0 fs=1 fc=2",
                            y_s[0], fs_s[0], fc_s[0]);
        end
      end
    end
  endtask

  task automatic test_repeat();
    int fs_cnt;
    fs_cnt = 0;
    for (int i = 0; i < 1043; i++) begin
      for (int ph = 0; ph < 2; ph++) begin
        cyc(1, lvl(1, ph), 1'b1, 1'b0, ph == 1);
        exp_o = q_exp.pop_front(); act_o = got(1); n_chk++;
        if (act_o !== exp_o) begin
          n_err++; $display("FAIL repeat i=%0d ph=%0d: got %h expected %h", i, ph, act_o, exp_o);
        end
        if (i > 0 && fs_s[1] === 1'b1) fs_cnt++;
      end
    end
    n_chk++;
    if (fs_cnt != 1 || y_s[1] !== 10'd0 || fc_s[1] !== 8'd1) begin
      n_err++; $display("FAIL repeat_frame: got fs_pulses=%0d y=%0d fc=%0d expected 1 0 1",
                        fs_cnt, y_s[1], fc_s[1]);
    end
  endtask

  task automatic test_edge_pol();
    int vs_hi;
    vs_hi = 0;
    for (int i = 0; i < 522; i++) begin
      for (int ph = 0; ph < 2; ph++) begin
        cyc(2, lvl(2, ph), 1'b1, 1'b0, ph == 1);
        exp_o = q_exp.pop_front(); act_o = got(2); n_chk++;
        if (act_o !== exp_o) begin
          n_err++; $display("FAIL edge_pol i=%0d ph=%0d: got %h expected %h", i, ph, act_o, exp_o);
        end
        if (ph == 1 && vs_s[2] === 1'b1) vs_hi++;
      end
    end
    n_chk++;
    if (vs_hi != 2 || y_s[2] !== 10'd0 || fc_s[2] !== 8'd1) begin
      n_err++; $display("FAIL edge_pol_frame: got vs_hi=%0d y=%0d fc=%0d expected 2 0 1",
                        vs_hi, y_s[2], fc_s[2]);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 250; i++) begin
      for (int ph = 0; ph < 2; ph++) begin
        cyc(0, lvl(0, ph), 1'b1, 1'b0, ph == 1);
        exp_o = q_exp.pop_front(); act_o = got(0); n_chk++;
        if (act_o !== exp_o) begin
          n_err++; $display("FAIL pre_reset i=%0d: got %h expected %h", i, act_o, exp_o);
        end
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    q_exp.push_back(mk(1'b0, 0, 0, 1'b0, 1'b0));
    exp_o = q_exp.pop_front(); act_o = got(0); n_chk++;
    if (act_o !== exp_o) begin
      n_err++; $display("FAIL async_reset: got %h expected %h", act_o, exp_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(0, (k == 1), 1'b1, 1'b0, (k == 2));
      exp_o = q_exp.pop_front(); act_o = got(0); n_chk++;
      if (act_o !== exp_o) begin
        n_err++; $display("FAIL reset_release k=%0d: got %h expected %h", k, act_o, exp_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_stop();
    test_resync();
    test_repeat();
    test_edge_pol();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
